linear_inverse_sm: RTL and testbench
====================================

# linear_inverse_SM

Sequential inverse of the 16-point piecewise-linear transform. For an output-domain value y it finds the segment k whose control points satisfy C_k <= y < C_(k+1). It then computes the input-domain value x = DM*k + floor((y - C_k)*DM / (C_(k+1) - C_k)) using a multi-cycle restoring divider. The block sits beside the forward transform and shares its control-point bus (C00..C15, knot positions DM*i). Calibration and readback paths use it to map corrected codes back to raw codes.

## Interface
- DSIZE, 12: data and control-point width, unsigned.
- DM, 16: knot spacing in the input domain; power of two, 2..256; DM*15 must fit in DSIZE.
- QW, log2(DM) (derived localparam, not overridable): quotient bits, which is also the number of divide cycles.

- clock  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cal_begin  in  1  start pulse; sampled only when busy=0.
- indata  in  DSIZE  y value; sampled in the cal_begin cycle.
- busy  out  1  high while a conversion is in flight.
- cal_valid  out  1  one-cycle pulse when outdata is updated.
- outdata  out  DSIZE  x result; held until the next cal_valid.
- C00..C15  in  DSIZE each  output-domain control points, unsigned; sampled in the cal_begin cycle only.

## Operation
- FSM states: IDLE, DIV, DONE.
  - IDLE -> DIV on cal_begin.
  - DIV -> DIV while the bit counter is above 0; DIV -> DONE when it reaches 0.
  - DONE -> DIV if cal_begin is high; otherwise DONE -> IDLE.
- Acceptance: cal_begin is accepted in IDLE or DONE and ignored in DIV.
- Segment search (combinational, in the accept cycle):
  - k = highest index 0..14 with C_k <= y.
  - Underflow: y < C00 and no k qualifies.
  - Overflow: y >= C15.
  - All comparisons are unsigned.
  - Rule priority: overflow is checked first, then underflow, then normal.
  - Because the highest qualifying k is taken, C_(k+1) > y always holds, so the divisor is never 0. Flat segments are skipped automatically, and non-monotonic tables never hang the block.
- Registered at accept:
  - base = DM*k;
  - remainder register N = y - C_k (DSIZE bits);
  - divisor D = C_(k+1) - C_k (DSIZE bits, nonzero);
  - mode (normal / under / over);
  - bit counter = QW-1.
- Restoring divide:
  - One quotient bit per DIV cycle, MSB first, QW cycles in total.
  - Each cycle: form the trial value 2*N. If it is >= D, the quotient bit is 1 and N = 2*N - D; otherwise the bit is 0 and N = 2*N.
  - Internal width of N is DSIZE+1.
  - The quotient is guaranteed < DM because N < D at start.
- Result, loaded into outdata on entry to DONE:
  - normal: base + q;
  - under: 0;
  - over: DM*15.
  - The under and over cases still run the full QW DIV cycles with q discarded, so latency is fixed.
- outdata changes only on the DIV -> DONE transition.

## Timing
- Reset values: state=IDLE, busy=0, cal_valid=0, outdata=0, counter=0.
- Latency: cal_begin accepted at cycle T gives DIV in cycles T+1..T+QW and cal_valid=1 at T+QW+1. For DM=16 that is 5 cycles.
- busy is 1 exactly in DIV cycles and 0 in IDLE and DONE, so it equals (state==DIV).
- Back-to-back: cal_begin in the DONE cycle is accepted. Sustained throughput is one result per QW+1 cycles, with no gaps.
- cal_begin during DIV: ignored, with no effect on the in-flight result or its latency.
- C00..C15 or indata changing after the accept cycle: no effect on the in-flight result.
- rst mid-DIV: the next cycle is IDLE with busy=0 and cal_valid=0; outdata is cleared to 0; the aborted result is never presented.
- rst and cal_begin in the same cycle: rst wins and nothing is accepted.
- No combinational path from any input to any output.

## Test plan
All scenarios use DSIZE=12 and DM=16 unless stated.
1. Uniform table, C_k=100*k. Input y=250 gives outdata=40; y=133 gives outdata=21 (5.28 floors to 5); y=1499 gives outdata=239. Each cal_valid arrives exactly 5 cycles after cal_begin, and busy is high for cycles 1..4.
2. Bounds. Table C_k=50+100*k: y=10 gives 0 (underflow) and y=50 gives 0. Table C_k=100*k: y=1500 gives 240 and y=4095 gives 240. Latency stays 5 in every case.
3. Flat and non-monotonic tables:
   - Table with C03=C04=300 and the other points at 100*k: y=300 gives 64, and the output never goes X.
   - Table with C05=900, C06=600 and the other points at 100*k: y=650 gives k=6; the result must match the reference model, with no hang.
4. Throughput and ignored starts. Issue cal_begin in every DONE cycle for 8 conversions: expect 8 cal_valid pulses spaced 5 cycles apart. Extra cal_begin pulses during DIV produce no additional results.
5. Reset abort: assert rst in the 2nd DIV cycle. Next cycle shows busy=0, cal_valid=0, outdata=0, and no cal_valid follows. A new y=250 afterwards returns 40.
6. DM=4, DSIZE=8, table C_k=10*k: y=25 gives 10. Latency is 3 cycles (QW=2).

Source files
------------

// File: rtl/linear_inverse_sm.sv
// Sequential inverse of the 16-point piecewise-linear transform: locates the
// segment holding y, then restoring-divides the in-segment offset into QW bits.
module linear_inverse_sm #(
  parameter int DSIZE = 12,
  parameter int DM    = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cal_begin,
  input  logic [DSIZE-1:0] indata,
  output logic             busy,
  output logic             cal_valid,
  output logic [DSIZE-1:0] outdata,
  input  logic [DSIZE-1:0] C00,
  input  logic [DSIZE-1:0] C01,
  input  logic [DSIZE-1:0] C02,
  input  logic [DSIZE-1:0] C03,
  input  logic [DSIZE-1:0] C04,
  input  logic [DSIZE-1:0] C05,
  input  logic [DSIZE-1:0] C06,
  input  logic [DSIZE-1:0] C07,
  input  logic [DSIZE-1:0] C08,
  input  logic [DSIZE-1:0] C09,
  input  logic [DSIZE-1:0] C10,
  input  logic [DSIZE-1:0] C11,
  input  logic [DSIZE-1:0] C12,
  input  logic [DSIZE-1:0] C13,
  input  logic [DSIZE-1:0] C14,
  input  logic [DSIZE-1:0] C15
);

  localparam int QW = $clog2(DM);
  localparam logic [DSIZE-1:0] OVER_VAL = DSIZE'(DM * 15);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  typedef enum logic [1:0] {MODE_NORM, MODE_UNDER, MODE_OVER} mode_t;

  state_t           state;
  state_t           state_next;
  mode_t            mode;
  mode_t            seg_mode;
  logic [DSIZE-1:0] cp [16];
  logic [3:0]       seg_k;
  logic             seg_found;
  logic             seg_over;
  logic             accept;
  logic [DSIZE:0]   n;
  logic [DSIZE:0]   trial;
  logic [DSIZE:0]   n_next;
  logic [DSIZE-1:0] d;
  logic [DSIZE-1:0] base;
  logic [QW-1:0]    q;
  logic [QW-1:0]    q_next;
  logic [QW-1:0]    cnt;
  logic             q_bit;
  logic [DSIZE-1:0] result;

  assign cp[0]  = C00;
  assign cp[1]  = C01;
  assign cp[2]  = C02;
  assign cp[3]  = C03;
  assign cp[4]  = C04;
  assign cp[5]  = C05;
  assign cp[6]  = C06;
  assign cp[7]  = C07;
  assign cp[8]  = C08;
  assign cp[9]  = C09;
  assign cp[10] = C10;
  assign cp[11] = C11;
  assign cp[12] = C12;
  assign cp[13] = C13;
  assign cp[14] = C14;
  assign cp[15] = C15;

  assign accept = cal_begin && (state != DIV);

  // Highest qualifying k wins, so C_(k+1) > y and the divisor is never zero.
  always_comb begin
    seg_k     = '0;
    seg_found = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (cp[i] <= indata) begin
        seg_k     = 4'(i);
        seg_found = 1'b1;
      end
    end
    seg_over = (indata >= cp[15]);
    if (seg_over)
      seg_mode = MODE_OVER;
    else if (!seg_found)
      seg_mode = MODE_UNDER;
    else
      seg_mode = MODE_NORM;
  end

  always_comb begin
    trial  = n << 1;
    q_bit  = (trial >= {1'b0, d});
    n_next = q_bit ? (trial - {1'b0, d}) : trial;
    q_next = (q << 1) | QW'(q_bit);
    case (mode)
      MODE_OVER:  result = OVER_VAL;
      MODE_UNDER: result = '0;
      default:    result = base + DSIZE'(q_next);
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = cal_begin ? DIV : IDLE;
      DIV:     state_next = (cnt == '0) ? DONE : DIV;
      DONE:    state_next = cal_begin ? DIV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == DIV);
    cal_valid = (state == DONE);
  end

  // Under/over conversions still run the full divide so latency never varies.
  always_ff @(posedge clock) begin
    if (rst) begin
      n       <= '0;
      d       <= '0;
      q       <= '0;
      base    <= '0;
      cnt     <= '0;
      mode    <= MODE_NORM;
      outdata <= '0;
    end else if (accept) begin
      mode <= seg_mode;
      base <= DSIZE'(seg_k) << QW;
      q    <= '0;
      cnt  <= QW'(QW - 1);
      if (seg_mode == MODE_NORM) begin
        n <= {1'b0, indata - cp[seg_k]};
        d <= cp[seg_k + 4'd1] - cp[seg_k];
      end else begin
        n <= '0;
        d <= DSIZE'(1);
      end
    end else if (state == DIV) begin
      n <= n_next;
      q <= q_next;
      if (cnt != '0)
        cnt <= cnt - QW'(1);
      else
        outdata <= result;
    end
  end

endmodule

// File: tb/tb_linear_inverse_sm.sv
// Self-checking bench for linear_inverse_sm: directed vectors, random tables
// against a segment-search/integer-divide model, throughput, reset abort, DM=4.
module tb_linear_inverse_sm;

  logic        clock;
  logic        rst;
  logic        cal_begin;
  logic [11:0] indata;
  logic        busy;
  logic        cal_valid;
  logic [11:0] outdata;
  logic [11:0] tbl [16];

  logic        s_cal_begin;
  logic [7:0]  s_indata;
  logic        s_busy;
  logic        s_cal_valid;
  logic [7:0]  s_outdata;
  logic [7:0]  s_tbl [16];

  int tab [16];
  int passed;
  int total;

  typedef struct {
    int    kind;
    int    y;
    int    exp_x;
    string name;
  } vec_t;

  vec_t vecs [11];

  linear_inverse_sm #(.DSIZE(12), .DM(16)) dut (
    .clock(clock), .rst(rst), .cal_begin(cal_begin), .indata(indata),
    .busy(busy), .cal_valid(cal_valid), .outdata(outdata),
    .C00(tbl[0]), .C01(tbl[1]), .C02(tbl[2]), .C03(tbl[3]),
    .C04(tbl[4]), .C05(tbl[5]), .C06(tbl[6]), .C07(tbl[7]),
    .C08(tbl[8]), .C09(tbl[9]), .C10(tbl[10]), .C11(tbl[11]),
    .C12(tbl[12]), .C13(tbl[13]), .C14(tbl[14]), .C15(tbl[15])
  );

  linear_inverse_sm #(.DSIZE(8), .DM(4)) dut_small (
    .clock(clock), .rst(rst), .cal_begin(s_cal_begin), .indata(s_indata),
    .busy(s_busy), .cal_valid(s_cal_valid), .outdata(s_outdata),
    .C00(s_tbl[0]), .C01(s_tbl[1]), .C02(s_tbl[2]), .C03(s_tbl[3]),
    .C04(s_tbl[4]), .C05(s_tbl[5]), .C06(s_tbl[6]), .C07(s_tbl[7]),
    .C08(s_tbl[8]), .C09(s_tbl[9]), .C10(s_tbl[10]), .C11(s_tbl[11]),
    .C12(s_tbl[12]), .C13(s_tbl[13]), .C14(s_tbl[14]), .C15(s_tbl[15])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inverse computed straight from the segment rules with integer arithmetic.
  function automatic int ref_x(input int y, input int c [16], input int dm);
    int k;
    if (y >= c[15]) return dm * 15;
    k = -1;
    for (int i = 14; i >= 0; i--) begin
      if (c[i] <= y) begin
        k = i;
        break;
      end
    end
    if (k < 0) return 0;
    return dm * k + ((y - c[k]) * dm) / (c[k + 1] - c[k]);
  endfunction

  task automatic check_output(input string name, input int got, input int exp);
    total++;
    if (got == exp)
      passed++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic load_table(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        1:       tab[i] = 50 + 100 * i;
        2:       tab[i] = (i == 3 || i == 4) ? 300 : 100 * i;
        3:       tab[i] = (i == 5) ? 900 : (i == 6) ? 600 : 100 * i;
        default: tab[i] = 100 * i;
      endcase
      tbl[i] = 12'(tab[i]);
    end
  endtask

  // Entered just after a rising edge; returns just after a rising edge.
  // Scrambles indata and the table once accepted to prove they are latched.
  task automatic apply_stimulus(input int y, output int x, output int lat,
                                output int busy_ok);
    cal_begin = 1'b1;
    indata    = 12'(y);
    @(posedge clock); #1;
    cal_begin = 1'b0;
    indata    = 12'($urandom);
    for (int i = 0; i < 16; i++) tbl[i] = 12'($urandom);
    lat     = 0;
    busy_ok = 1;
    x       = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (cal_valid) begin
        lat = c;
        x   = int'(outdata);
        if (busy) busy_ok = 0;
        break;
      end
      if (!busy) busy_ok = 0;
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    for (int i = 0; i < 16; i++) tbl[i] = 12'(tab[i]);
  endtask

  initial begin
    int x, lat, bok, pulses, exp_y, last_x;
    int ys [8];

    passed = 0;
    total  = 0;
    rst = 1'b1;
    cal_begin = 1'b0;
    indata = '0;
    s_cal_begin = 1'b0;
    s_indata = '0;
    for (int i = 0; i < 16; i++) s_tbl[i] = 8'(10 * i);
    load_table(0);

    vecs[0]  = '{0, 250,  40,  "uniform_250"};
    vecs[1]  = '{0, 133,  21,  "uniform_133"};
    vecs[2]  = '{0, 1499, 239, "uniform_1499"};
    vecs[3]  = '{1, 10,   0,   "underflow_10"};
    vecs[4]  = '{1, 50,   0,   "at_c00_50"};
    vecs[5]  = '{0, 1500, 240, "at_c15_1500"};
    vecs[6]  = '{0, 4095, 240, "overflow_4095"};
    vecs[7]  = '{2, 300,  64,  "flat_300"};
    vecs[8]  = '{3, 650,  104, "nonmono_650"};
    vecs[9]  = '{0, 0,    0,   "uniform_0"};
    vecs[10] = '{0, 1401, 224, "uniform_1401"};

    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_valid", int'(cal_valid), 0);
    check_output("reset_outdata", int'(outdata), 0);
    check_output("reset_small_outdata", int'(s_outdata), 0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(posedge clock); #1;

    foreach (vecs[v]) begin
      load_table(vecs[v].kind);
      check_output({vecs[v].name, "_model"}, ref_x(vecs[v].y, tab, 16), vecs[v].exp_x);
      apply_stimulus(vecs[v].y, x, lat, bok);
      check_output(vecs[v].name, x, vecs[v].exp_x);
      check_output({vecs[v].name, "_latency"}, lat, 5);
      check_output({vecs[v].name, "_busy"}, bok, 1);
    end

    for (int r = 0; r < 40; r++) begin
      int acc;
      acc = int'($urandom_range(0, 100));
      for (int i = 0; i < 16; i++) begin
        if (r % 2 == 0) begin
          tab[i] = acc;
          acc += int'($urandom_range(0, 260));
        end else begin
          tab[i] = int'($urandom_range(0, 4095));
        end
        tbl[i] = 12'(tab[i]);
      end
      exp_y = int'($urandom_range(0, 4095));
      apply_stimulus(exp_y, x, lat, bok);
      check_output("random_x", x, ref_x(exp_y, tab, 16));
      check_output("random_latency", lat, 5);
    end

    // Back-to-back with cal_begin held high: only DONE-cycle starts count.
    load_table(0);
    for (int i = 0; i < 8; i++) ys[i] = int'($urandom_range(0, 1600));
    pulses = 0;
    for (int t = 0; t < 50; t++) begin
      cal_begin = (t <= 35);
      indata = (t % 5 == 0 && t < 40) ? 12'(ys[t / 5]) : 12'($urandom);
      @(negedge clock);
      check_output("tput_busy", int'(busy), (t >= 1 && t <= 39 && t % 5 != 0) ? 1 : 0);
      if (cal_valid) begin
        pulses++;
        check_output("tput_valid_time", t, 5 * pulses);
        if (pulses <= 8)
          check_output("tput_x", int'(outdata), ref_x(ys[pulses - 1], tab, 16));
      end
      @(posedge clock); #1;
    end
    check_output("tput_pulses", pulses, 8);
    cal_begin = 1'b0;

    // Reset in the 2nd DIV cycle, then reset together with a start.
    load_table(0);
    apply_stimulus(1499, x, lat, bok);
    last_x = x;
    check_output("abort_pre_x", last_x, 239);
    cal_begin = 1'b1;
    indata = 12'd250;
    @(posedge clock); #1;
    cal_begin = 1'b0;
    @(posedge clock); #1;
    rst = 1'b1;
    @(posedge clock); #1;
    cal_begin = 1'b1;
    @(negedge clock);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_valid", int'(cal_valid), 0);
    check_output("abort_outdata", int'(outdata), 0);
    @(posedge clock); #1;
    rst = 1'b0;
    cal_begin = 1'b0;
    @(negedge clock);
    check_output("rst_beats_start_busy", int'(busy), 0);
    pulses = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      if (cal_valid) pulses++;
    end
    check_output("abort_no_valid", pulses, 0);
    @(posedge clock); #1;
    apply_stimulus(250, x, lat, bok);
    check_output("after_abort_x", x, 40);
    check_output("after_abort_latency", lat, 5);

    // Narrow instance: DSIZE=8, DM=4, C_k=10*k, three-cycle latency.
    begin
      int sy [3];
      int sx [3];
      sy = '{25, 149, 200};
      sx = '{10, 59, 60};
      for (int v = 0; v < 3; v++) begin
        s_cal_begin = 1'b1;
        s_indata = 8'(sy[v]);
        @(posedge clock); #1;
        s_cal_begin = 1'b0;
        s_indata = 8'($urandom);
        lat = 0;
        x = -1;
        for (int c = 1; c <= 10; c++) begin
          @(negedge clock);
          if (s_cal_valid) begin
            lat = c;
            x = int'(s_outdata);
            break;
          end
          @(posedge clock); #1;
        end
        check_output("small_x", x, sx[v]);
        check_output("small_latency", lat, 3);
        @(posedge clock); #1;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
